rfile_p: RTL and testbench

RFILE_P -- requirements
Module: rfile_p

---
 rtl/rfile_pkg.sv | 13 +
 rtl/rfile_clr_seq.sv | 58 +++++
 rtl/rfile_p.sv | 88 ++++++++
 tb/tb_rfile_p.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rfile_pkg.sv
// Shared constants and clear-sequencer state encoding for the rfile_p register file.
package rfile_pkg;

  localparam int BW_DEF   = 8;
  localparam int NREG_DEF = 9;
  localparam int AW_DEF   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/rfile_clr_seq.sv
// Clear sequencer: walks cnt over 0..NREG-1, one register per cycle, holding busy meanwhile.
// Starts the cycle after clr in IDLE; clr while clearing is ignored; rst aborts.
module rfile_clr_seq
  import rfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  output logic          clr_en_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          busy_o
);

  clr_state_e    state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == AW'(NREG - 1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // busy_q is high exactly while in CLEAR, so it doubles as the clear strobe
  assign clr_en_o   = busy_q;
  assign clr_addr_o = cnt_q;
  assign busy_o     = busy_q;

endmodule

// File: rtl/rfile_p.sv
// Register file, 1 write / 2 registered read ports (latency 1), r0/r1 taps, sequenced clear.
// Define RFILE_P_BYPASS_EN for write-first forwarding of a same-cycle accepted write to the read ports.
module rfile_p
  import rfile_pkg::*;
#(
  parameter int BW   = BW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] din,
  input  logic          rw,
  input  logic [AW-1:0] da,
  input  logic [AW-1:0] aa,
  input  logic [AW-1:0] ba,
  input  logic          clr,
  output logic [BW-1:0] adata,
  output logic [BW-1:0] bdata,
  output logic [BW-1:0] r0,
  output logic [BW-1:0] r1,
  output logic          busy
);

  logic [BW-1:0] regs_q [NREG];
  logic [BW-1:0] adata_q, bdata_q;
  logic [BW-1:0] adata_d, bdata_d;
  logic [BW-1:0] rd_a, rd_b;
  logic          clr_en;
  logic [AW-1:0] clr_addr;
  logic          busy_w;
  logic          wr_en;

  rfile_clr_seq #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr),
    .busy_o     (busy_w)
  );

  // clr wins over rw in the same cycle; nothing is written while clearing
  assign wr_en = rw && !busy_w && !clr && ({1'b0, da} < (AW+1)'(NREG));

  // Addresses >= NREG match no entry and read back as zero
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (aa == AW'(i)) rd_a = regs_q[i];
      if (ba == AW'(i)) rd_b = regs_q[i];
    end
  end

`ifdef RFILE_P_BYPASS_EN
  assign adata_d = (wr_en && (da == aa)) ? din : rd_a;
  assign bdata_d = (wr_en && (da == ba)) ? din : rd_b;
`else
  assign adata_d = rd_a;
  assign bdata_d = rd_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      adata_q <= '0;
      bdata_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (clr_en && (clr_addr == AW'(i))) regs_q[i] <= '0;
        else if (wr_en && (da == AW'(i))) regs_q[i] <= din;
      end
      adata_q <= adata_d;
      bdata_q <= bdata_d;
    end
  end

  assign adata = adata_q;
  assign bdata = bdata_q;
  assign r0    = regs_q[0];
  assign r1    = regs_q[1];
  assign busy  = busy_w;

endmodule

// File: tb/tb_rfile_p.sv
// Bench for rfile_p: directed scenarios with literal expectations plus random traffic vs. a behavioural model.
module tb_rfile_p;

  localparam int NREG = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       rw  = 1'b0;
  logic [3:0] da  = '0;
  logic [3:0] aa  = '0;
  logic [3:0] ba  = '0;
  logic       clr = 1'b0;
  logic [7:0] adata, bdata, r0, r1;
  logic       busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  rfile_p dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .rw    (rw),
    .da    (da),
    .aa    (aa),
    .ba    (ba),
    .clr   (clr),
    .adata (adata),
    .bdata (bdata),
    .r0    (r0),
    .r1    (r1),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: contents array, remaining clear cycles, expected read outputs
  logic [7:0] mem [16];
  int         clr_left = 0;
  logic [7:0] ea = '0, eb = '0;

  always @(posedge clk) begin
    logic [7:0] va, vb;
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      ea = '0;
      eb = '0;
      clr_left = 0;
    end else begin
      va = (int'(aa) < NREG) ? mem[aa] : 8'h00;
      vb = (int'(ba) < NREG) ? mem[ba] : 8'h00;
      if (clr_left > 0) begin
        mem[NREG - clr_left] = '0;
        clr_left--;
      end else if (clr) begin
        clr_left = NREG;
      end else if (rw && int'(da) < NREG) begin
`ifdef RFILE_P_BYPASS_EN
        if (aa == da) va = din;
        if (ba == da) vb = din;
`endif
        mem[da] = din;
      end
      ea = va;
      eb = vb;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_adata", {24'd0, adata}, {24'd0, ea});
      chk("model_bdata", {24'd0, bdata}, {24'd0, eb});
      chk("model_r0", {24'd0, r0}, {24'd0, mem[0]});
      chk("model_r1", {24'd0, r1}, {24'd0, mem[1]});
      chk("model_busy", {31'd0, busy}, {31'd0, (clr_left > 0)});
    end
  end

  // Apply one cycle of inputs, return at the following falling edge
  task automatic cyc(input logic r, input logic w, input logic [3:0] a_d, input logic [7:0] d,
                     input logic [3:0] a_a, input logic [3:0] a_b, input logic c);
    rst = r; rw = w; da = a_d; din = d; aa = a_a; ba = a_b; clr = c;
    @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] a_a);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, a_a, 4'd0, 1'b0);
  endtask

  task automatic fill();
    for (int i = 0; i < NREG; i++) cyc(1'b0, 1'b1, 4'(i), 8'(8'h10 + i), 4'd0, 4'd0, 1'b0);
  endtask

  int n;

  initial begin
    // reset state
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
    chk_en = 1'b1;
    chk("rst_adata", {24'd0, adata}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_r0", {24'd0, r0}, 32'h0);

    // basic write then read
    cyc(1'b0, 1'b1, 4'd3, 8'h2A, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 4'd3, 1'b0);
    chk("wr_rd_adata", {24'd0, adata}, 32'h2A);
    chk("wr_rd_bdata", {24'd0, bdata}, 32'h2A);
    chk("wr_rd_r0", {24'd0, r0}, 32'h0);
    chk("wr_rd_r1", {24'd0, r1}, 32'h0);

    // same-cycle write/read collision
    cyc(1'b0, 1'b1, 4'd5, 8'h77, 4'd5, 4'd0, 1'b0);
`ifdef RFILE_P_BYPASS_EN
    chk("collide_adata", {24'd0, adata}, 32'h77);
`else
    chk("collide_adata", {24'd0, adata}, 32'h00);
`endif
    idle(4'd5);
    chk("collide_after", {24'd0, adata}, 32'h77);

    // out-of-range write and read
    cyc(1'b0, 1'b1, 4'd9, 8'hFF, 4'd9, 4'd3, 1'b0);
    chk("oor_adata", {24'd0, adata}, 32'h0);
    chk("oor_bdata", {24'd0, bdata}, 32'h2A);

    // full clear: busy length, writes dropped, contents zero afterwards
    fill();
    idle(4'd8);
    chk("fill_r1", {24'd0, r1}, 32'h11);
    chk("fill_adata8", {24'd0, adata}, 32'h18);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
    n = 0;
    while (busy && n < 20) begin
      n++;
      cyc(1'b0, 1'b1, 4'd2, 8'hAA, 4'd0, 4'd0, 1'b0);
    end
    chk("clr_busy_cycles", n, NREG);
    for (int i = 0; i < NREG; i++) begin
      idle(4'(i));
      chk("clr_read_zero", {24'd0, adata}, 32'h0);
    end

    // clr and rw together: write dropped, clear runs
    cyc(1'b0, 1'b1, 4'd1, 8'h55, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 1'b1, 4'd1, 8'h11, 4'd0, 4'd0, 1'b1);
    chk("clrrw_r1", {24'd0, r1}, 32'h55);
    chk("clrrw_busy", {31'd0, busy}, 32'h1);
    n = 0;
    while (busy && n < 20) begin
      n++;
      idle(4'd1);
    end
    chk("clrrw_r1_done", {24'd0, r1}, 32'h0);

    // reset in the middle of a clear
    fill();
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
    idle(4'd0);
    idle(4'd0);
    idle(4'd0);
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 4'd8, 4'd0, 1'b0);
    chk("midrst_busy", {31'd0, busy}, 32'h0);
    idle(4'd8);
    chk("midrst_reg8", {24'd0, adata}, 32'h0);
    cyc(1'b0, 1'b1, 4'd4, 8'h3C, 4'd0, 4'd0, 1'b0);
    idle(4'd4);
    chk("midrst_write", {24'd0, adata}, 32'h3C);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [3:0] wd;
      r  = $urandom_range(0, 199);
      wd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, NREG - 1));
      cyc(r == 0, $urandom_range(0, 2) != 0, wd, 8'($urandom),
          ($urandom_range(0, 2) == 0) ? wd : 4'($urandom_range(0, 15)),
          ($urandom_range(0, 2) == 0) ? wd : 4'($urandom_range(0, 15)),
          (r > 0 && r < 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
